fpmult_issue_arbiter: RTL and testbench

//   Shares one fixed-latency FPMult pipeline (unpack/multiply/normalize/round) between NREQ requesters.

---
 rtl/fpmult_issue_arbiter_pkg.sv | 21 ++
 rtl/fpmult_rr_pick.sv | 36 +++
 rtl/fpmult_issue_arbiter.sv | 150 +++++++++++++++
 tb/tb_fpmult_issue_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpmult_issue_arbiter_pkg.sv
// Shared FPMult widths/latency and arbiter helpers; the top adds perf counters under FPMULT_ARB_PERF_EN.
// Macros are guarded so this header can sit alongside other FPMult sources.
`ifndef FPMULT_DEFS_DONE
`define FPMULT_DEFS_DONE
`define DWIDTH 32
`define EXPONENT 8
`define MANTISSA 23
`define FPM_FLAGW 5
`define FPM_LAT 4
`endif

package fpmult_issue_arbiter_pkg;
  localparam int FPM_DW    = `DWIDTH;
  localparam int FPM_FLAGW = `FPM_FLAGW;
  localparam int FPM_LAT   = `FPM_LAT;
  localparam int PERF_CW   = 16;

  function automatic logic [PERF_CW-1:0] sat_inc(input logic [PERF_CW-1:0] v);
    return (&v) ? v : v + PERF_CW'(1);
  endfunction
endpackage

// File: rtl/fpmult_rr_pick.sv
// Round-robin picker: rotate req by ptr, keep lowest set bit, rotate back. Combinational, 0 cycles.
// No backpressure of its own; win is one-hot or zero and depends only on req and ptr.
module fpmult_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] win
);

  logic [NREQ-1:0] req_rot;
  logic [NREQ-1:0] win_rot;

  // Constant-index muxing per pointer value keeps every select in range for any NREQ.
  always_comb begin
    req_rot = '0;
    win     = '0;
    for (int p = 0; p < NREQ; p++) begin
      if (ptr == IDW'(p)) begin
        for (int j = 0; j < NREQ; j++) begin
          req_rot[j] = req[(p + j) % NREQ];
        end
      end
    end
    win_rot = req_rot & (-req_rot);
    for (int p = 0; p < NREQ; p++) begin
      if (ptr == IDW'(p)) begin
        for (int j = 0; j < NREQ; j++) begin
          win[(p + j) % NREQ] = win_rot[j];
        end
      end
    end
  end

endmodule

// File: rtl/fpmult_issue_arbiter.sv
// Shares one LAT-cycle FPMult among NREQ requesters; handshake to rsp_valid is LAT+2 cycles, 1 op/cycle.
// issue_en=0 withholds grants only; results are never stalled. FPMULT_ARB_PERF_EN adds grant/conflict counters.
module fpmult_issue_arbiter
  import fpmult_issue_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int LAT  = FPM_LAT,
  parameter int DW   = FPM_DW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*DW-1:0]   req_a,
  input  logic [NREQ*DW-1:0]   req_b,
  output logic [DW-1:0]        mul_a,
  output logic [DW-1:0]        mul_b,
  input  logic [DW-1:0]        mul_z,
  input  logic [FPM_FLAGW-1:0] mul_flags,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [DW-1:0]        rsp_z,
  output logic [FPM_FLAGW-1:0] rsp_flags,
  output logic                 busy
`ifdef FPMULT_ARB_PERF_EN
  ,
  output logic [NREQ*16-1:0]   grant_cnt,
  output logic [15:0]          conflict_cnt
`endif
);

  logic [NREQ-1:0]          win;
  logic                     xfer;
  logic [IDW-1:0]           gnt_idx;

  logic [IDW-1:0]           ptr_q, ptr_d;
  logic [DW-1:0]            mul_a_q, mul_a_d;
  logic [DW-1:0]            mul_b_q, mul_b_d;
  logic [LAT:0]             tag_vld_q, tag_vld_d;
  logic [LAT:0][IDW-1:0]    tag_id_q, tag_id_d;
  logic [NREQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]           rsp_id_q, rsp_id_d;
  logic [DW-1:0]            rsp_z_q, rsp_z_d;
  logic [FPM_FLAGW-1:0]     rsp_flags_q, rsp_flags_d;

  fpmult_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .win (win)
  );

  assign req_ready = issue_en ? win : '0;

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) gnt_idx = IDW'(i);
    end
    xfer    = |(req_valid & req_ready);

    ptr_d   = ptr_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    if (xfer) begin
      ptr_d   = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
      mul_a_d = req_a[gnt_idx*DW +: DW];
      mul_b_d = req_b[gnt_idx*DW +: DW];
    end

    // Stage k holds the op whose operands reached FPMult k cycles ago; stage LAT lines up with mul_z.
    tag_vld_d = {tag_vld_q[LAT-1:0], xfer};
    tag_id_d  = {tag_id_q[LAT-1:0], gnt_idx};

    rsp_valid_d = '0;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
    rsp_flags_d = rsp_flags_q;
    if (tag_vld_q[LAT]) begin
      rsp_valid_d[tag_id_q[LAT]] = 1'b1;
      rsp_id_d    = tag_id_q[LAT];
      rsp_z_d     = mul_z;
      rsp_flags_d = mul_flags;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      rsp_valid_q <= '0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
      rsp_flags_q <= '0;
    end else begin
      ptr_q       <= ptr_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_flags = rsp_flags_q;
  assign busy      = (|tag_vld_q) | (|rsp_valid_q);

`ifdef FPMULT_ARB_PERF_EN
  logic [NREQ-1:0][15:0] grant_cnt_q, grant_cnt_d;
  logic [15:0]           conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    grant_cnt_d = grant_cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && req_ready[i]) grant_cnt_d[i] = sat_inc(grant_cnt_q[i]);
    end
    conflict_cnt_d = conflict_cnt_q;
    if (issue_en && ($countones(req_valid) >= 2)) conflict_cnt_d = conflict_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt_q    <= '0;
      conflict_cnt_q <= '0;
    end else begin
      grant_cnt_q    <= grant_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign grant_cnt    = grant_cnt_q;
  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_fpmult_issue_arbiter.sv
// Bench for fpmult_issue_arbiter with a behavioural FPMult stub and an issue-order scoreboard.
`timescale 1ns/1ps
module tb_fpmult_issue_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 4;
  localparam int DW   = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               issue_en = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_a, req_b;
  logic [DW-1:0]      mul_a, mul_b, mul_z;
  logic [4:0]         mul_flags;
  logic [NREQ-1:0]    rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [DW-1:0]      rsp_z;
  logic [4:0]         rsp_flags;
  logic               busy;
`ifdef FPMULT_ARB_PERF_EN
  logic [NREQ*16-1:0] grant_cnt;
  logic [15:0]        conflict_cnt;
`endif

  fpmult_issue_arbiter #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT), .DW(DW)) dut (
    .clk(clk), .rst(rst), .issue_en(issue_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z), .mul_flags(mul_flags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_flags(rsp_flags),
    .busy(busy)
`ifdef FPMULT_ARB_PERF_EN
    , .grant_cnt(grant_cnt), .conflict_cnt(conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Truncating single-precision multiply for normal operands; flags = {0000, inexact}.
  function automatic logic [36:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] m;
    logic        inx;
    int          e;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      m = p[46:24]; inx = |p[23:0]; e = e + 1;
    end else begin
      m = p[45:23]; inx = |p[22:0];
    end
    return {4'b0000, inx, a[31] ^ b[31], e[7:0], m};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    r[30:23] = 8'($urandom_range(100, 150));
    return r;
  endfunction

  logic [36:0] fpm_pipe [LAT];
  always @(posedge clk) begin
    fpm_pipe[0] <= fpmul(mul_a, mul_b);
    for (int k = 1; k < LAT; k++) fpm_pipe[k] <= fpm_pipe[k-1];
  end
  assign {mul_flags, mul_z} = fpm_pipe[LAT-1];

  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];
  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      req_a[k*DW +: DW] = op_a[k];
      req_b[k*DW +: DW] = op_b[k];
    end
  end

  typedef struct {
    int          issue;
    int          id;
    logic [31:0] z;
    logic [4:0]  fl;
  } op_t;

  op_t            inflight[$];
  int             m_ptr, m_t;
  logic [IDW-1:0] last_id;
  logic [31:0]    last_z;
  logic [4:0]     last_fl;
  int             total = 0;
  int             bad = 0;

  task automatic release_reset();
    rst = 1'b0; issue_en = 1'b0; req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    inflight.delete();
    m_ptr = 0; m_t = 0; last_id = '0; last_z = '0; last_fl = '0;
  endtask

  // One clock: drive inputs, sample DUT at negedge, advance the scoreboard, refresh granted operands.
  // obs/expv layout: {req_ready, rsp_valid, rsp_id, rsp_z, rsp_flags, busy}.
  task automatic cycle(input logic en, input logic [NREQ-1:0] vld,
                       output logic [47:0] obs, output logic [47:0] expv, output int gid);
    logic [NREQ-1:0] e_rdy, e_rv;
    logic            e_busy;
    op_t             o;
    int              idx;
    issue_en = en; req_valid = vld;
    @(negedge clk);
    obs = {req_ready, rsp_valid, rsp_id, rsp_z, rsp_flags, busy};
    gid = -1;
    if (en) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (gid < 0 && vld[idx]) gid = idx;
      end
    end
    e_rdy = '0;
    if (gid >= 0) e_rdy[gid] = 1'b1;
    e_busy = 1'b0;
    foreach (inflight[j]) if (inflight[j].issue + 1 <= m_t) e_busy = 1'b1;
    e_rv = '0;
    if (inflight.size() > 0 && inflight[0].issue + LAT + 2 == m_t) begin
      o = inflight.pop_front();
      e_rv[o.id] = 1'b1;
      last_id = IDW'(o.id); last_z = o.z; last_fl = o.fl;
    end
    if (gid >= 0) begin
      o.issue = m_t; o.id = gid;
      {o.fl, o.z} = fpmul(op_a[gid], op_b[gid]);
      inflight.push_back(o);
      m_ptr = (gid + 1) % NREQ;
    end
    m_t++;
    expv = {e_rdy, e_rv, last_id, last_z, last_fl, e_busy};
    @(posedge clk); #1;
    if (gid >= 0) begin
      op_a[gid] = rand_op(); op_b[gid] = rand_op();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; issue_en = 1'b1; req_valid = '0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({mul_a, mul_b, rsp_valid, rsp_id, rsp_z, rsp_flags, busy, req_ready} !== '0) begin
      bad++;
      $display("FAIL reset_state got=%h want=0", {mul_a, mul_b, rsp_valid, rsp_id, rsp_z, rsp_flags, busy, req_ready});
    end
    release_reset();
  endtask

  task automatic test_rr_all4();
    logic [47:0] obs, expv;
    int          gid, nrsp, prev_t;
    nrsp = 0; prev_t = -1;
    for (int i = 0; i < 8 + LAT + 4; i++) begin
      cycle(1'b1, (i < 8) ? 4'b1111 : 4'b0000, obs, expv, gid);
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL rr_all4 t=%0d got=%h want=%h", m_t - 1, obs, expv);
      end
      if (i < 8) begin
        total++;
        if (obs[47:44] !== 4'(1 << (i % 4))) begin
          bad++; $display("FAIL rr_all4_grant i=%0d got=%b want=%b", i, obs[47:44], 4'(1 << (i % 4)));
        end
      end
      if (obs[43:40] != 4'b0000) begin
        total++;
        if (obs[39:38] !== IDW'(nrsp % 4) || (prev_t >= 0 && prev_t != i - 1)) begin
          bad++; $display("FAIL rr_all4_rsp n=%0d got_id=%0d want_id=%0d", nrsp, obs[39:38], nrsp % 4);
        end
        nrsp++; prev_t = i;
      end
    end
    total++;
    if (nrsp != 8) begin
      bad++; $display("FAIL rr_all4_count got=%0d want=8", nrsp);
    end
  endtask

  task automatic test_single_op();
    logic [47:0] obs, expv;
    int          gid;
    op_a[0] = 32'h3FC00000; op_b[0] = 32'h40000000;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, (i == 0) ? 4'b0001 : 4'b0000, obs, expv, gid);
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL single_op t=%0d got=%h want=%h", m_t - 1, obs, expv);
      end
      total++;
      if (i == 0 && obs[47:44] !== 4'b0001) begin
        bad++; $display("FAIL single_op_ready got=%b want=0001", obs[47:44]);
      end else if (i == 6 && (obs[43:40] !== 4'b0001 || obs[37:6] !== 32'h40400000 || obs[5:1] !== 5'd0)) begin
        bad++; $display("FAIL single_op_rsp got_v=%b got_z=%h got_f=%h want 0001/40400000/00", obs[43:40], obs[37:6], obs[5:1]);
      end else if (i != 0 && i != 6 && obs[43:40] !== 4'b0000) begin
        bad++; $display("FAIL single_op_stray i=%0d got=%b want=0000", i, obs[43:40]);
      end
    end
  endtask

  task automatic test_ptr_wrap();
    logic [47:0]     obs, expv;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] want [3];
    int              gid;
    want[0] = 4'b1000; want[1] = 4'b0001; want[2] = 4'b0010;
    cycle(1'b1, 4'b0010, obs, expv, gid);
    total++;
    if (obs !== expv) begin
      bad++; $display("FAIL ptr_setup got=%h want=%h", obs, expv);
    end
    pend = 4'b1011;
    for (int i = 0; i < 3 + LAT + 3; i++) begin
      cycle(1'b1, pend, obs, expv, gid);
      if (gid >= 0) pend[gid] = 1'b0;
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL ptr_wrap t=%0d got=%h want=%h", m_t - 1, obs, expv);
      end
      if (i < 3) begin
        total++;
        if (obs[47:44] !== want[i]) begin
          bad++; $display("FAIL ptr_wrap_grant i=%0d got=%b want=%b", i, obs[47:44], want[i]);
        end
      end
    end
  endtask

  task automatic test_issue_en();
    logic [47:0] obs, expv;
    int          gid;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 4'b1111, obs, expv, gid);
      total++;
      if (obs !== expv || obs[47:44] !== 4'b0000 || obs[43:40] !== 4'b0000 || obs[0] !== 1'b0) begin
        bad++; $display("FAIL issue_en_off t=%0d got=%h want=%h", m_t - 1, obs, expv);
      end
    end
    cycle(1'b1, 4'b1111, obs, expv, gid);
    total++;
    if (obs !== expv || obs[47:44] !== 4'b0100) begin
      bad++; $display("FAIL issue_en_resume got=%h want=%h", obs, expv);
    end
    for (int i = 0; i < LAT + 3; i++) begin
      cycle(1'b1, 4'b0000, obs, expv, gid);
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL issue_en_drain t=%0d got=%h want=%h", m_t - 1, obs, expv);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [47:0] obs, expv;
    int          gid;
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b1111, obs, expv, gid);
    req_valid = '0;
    rst = 1'b0;
    #1;
    total++;
    if ({mul_a, mul_b, rsp_valid, rsp_id, rsp_z, rsp_flags, busy, req_ready} !== '0) begin
      bad++;
      $display("FAIL reset_mid_outputs got=%h want=0", {mul_a, mul_b, rsp_valid, rsp_id, rsp_z, rsp_flags, busy, req_ready});
    end
    @(posedge clk); #1 rst = 1'b1;
    inflight.delete();
    m_ptr = 0; m_t = 0; last_id = '0; last_z = '0; last_fl = '0;
    for (int i = 0; i < LAT + 6; i++) begin
      cycle(1'b1, 4'b0000, obs, expv, gid);
      total++;
      if (obs !== expv || obs[43:40] !== 4'b0000) begin
        bad++; $display("FAIL reset_mid_quiet t=%0d got=%h want=%h", m_t - 1, obs, expv);
      end
    end
  endtask

  task automatic test_random();
    logic [47:0]     obs, expv;
    logic [NREQ-1:0] pend;
    int              gid;
    pend = '0;
    for (int i = 0; i < 400 + LAT + 3; i++) begin
      if (i < 400) pend = pend | NREQ'($urandom_range(0, 15));
      else         pend = '0;
      cycle($urandom_range(0, 7) != 0, pend, obs, expv, gid);
      if (gid >= 0) pend[gid] = 1'b0;
      total++;
      if (obs !== expv) begin
        bad++; $display("FAIL random t=%0d got=%h want=%h", m_t - 1, obs, expv);
      end
    end
  endtask

`ifdef FPMULT_ARB_PERF_EN
  task automatic test_perf();
    release_reset();
    total++;
    if (grant_cnt !== '0 || conflict_cnt !== '0) begin
      bad++; $display("FAIL perf_reset got=%h/%h want=0", grant_cnt, conflict_cnt);
    end
    issue_en = 1'b1; req_valid = 4'b0010;
    repeat (70000) @(posedge clk);
    #1 req_valid = '0;
    total++;
    if (grant_cnt !== {16'h0000, 16'h0000, 16'hFFFF, 16'h0000} || conflict_cnt !== 16'd0) begin
      bad++; $display("FAIL perf_sat got=%h/%h want=0000_0000_ffff_0000/0", grant_cnt, conflict_cnt);
    end
    req_valid = 4'b1111;
    repeat (3) @(posedge clk);
    #1 req_valid = '0;
    total++;
    if (conflict_cnt !== 16'd3) begin
      bad++; $display("FAIL perf_conflict got=%0d want=3", conflict_cnt);
    end
  endtask
`endif

  initial begin
    for (int k = 0; k < NREQ; k++) begin
      op_a[k] = rand_op(); op_b[k] = rand_op();
    end
    test_reset();
    test_rr_all4();
    test_single_op();
    test_ptr_wrap();
    test_issue_en();
    test_reset_mid();
    test_random();
`ifdef FPMULT_ARB_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
